// File: rtl/dcim_pkg.sv
// Shared constants for the DCIM readout path: macro widths, result-tag field layout
// and the collector FSM state encoding.
package dcim_pkg;

   localparam int DCIM_NOUT_W = 51;
   localparam int DCIM_D_W    = 24;
   localparam int DCIM_WA_W   = 8;
   localparam int DCIM_XIN_W  = 192;

   // Tag = {seq, cima, inwidth, wwidth}; the mode bits sit below the sequence number.
   localparam int TAG_WW_BIT   = 0;
   localparam int TAG_IW_BIT   = 1;
   localparam int TAG_CIMA_BIT = 2;
   localparam int TAG_MODE_W   = 3;
   localparam int TAG_SEQ_LSB  = TAG_MODE_W;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_ARMED = 1'b1
   } dcim_state_e;

   function automatic logic [TAG_MODE_W-1:0] pack_mode(input logic cima, input logic iw,
                                                       input logic ww);
      logic [TAG_MODE_W-1:0] m;
      m               = '0;
      m[TAG_CIMA_BIT] = cima;
      m[TAG_IW_BIT]   = iw;
      m[TAG_WW_BIT]   = ww;
      return m;
   endfunction

endpackage

// File: rtl/dcim_sync_fifo.sv
// First-word-fall-through synchronous FIFO with exact occupancy; a push while full is
// accepted only when a pop frees the head slot in the same cycle.
module dcim_sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push_i,
   input  logic [WIDTH-1:0]           data_i,
   input  logic                       pop_i,
   output logic [WIDTH-1:0]           data_o,
   output logic                       valid_o,
   output logic                       full_o,
   output logic [$clog2(DEPTH+1)-1:0] level_o
);

   localparam int AW    = $clog2(DEPTH);
   localparam int LVL_W = $clog2(DEPTH+1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_q, rd_q;
   logic [LVL_W-1:0] cnt_q;
   logic             empty, full, do_push, do_pop;

   assign empty   = (cnt_q == '0);
   assign full    = (cnt_q == LVL_W'(DEPTH));
   assign do_pop  = pop_i & ~empty;
   assign do_push = push_i & (~full | do_pop);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (do_push) wr_q <= wr_q + 1'b1;
         if (do_pop)  rd_q <= rd_q + 1'b1;
         case ({do_push, do_pop})
            2'b10:   cnt_q <= cnt_q + 1'b1;
            2'b01:   cnt_q <= cnt_q - 1'b1;
            default: cnt_q <= cnt_q;
         endcase
      end
   end

   // Storage carries no reset; emptiness alone qualifies the head.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_q] <= data_i;
   end

   assign data_o  = empty ? '0 : mem_q[rd_q];
   assign valid_o = ~empty;
   assign full_o  = full;
   assign level_o = cnt_q;

endmodule

// File: rtl/dcim_result_collector.sv
// Tags each macro job launched by start, captures nout on the rising edge of st and
// queues {seq, cima, inwidth, wwidth, nout} into a valid/ready result FIFO.
module dcim_result_collector
   import dcim_pkg::*;
#(
   parameter int NOUT_W  = DCIM_NOUT_W,
   parameter int SEQ_W   = 4,
   parameter int DEPTH   = 4,
   parameter int TIMEOUT = 1024
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          start,
   input  logic                          cima,
   input  logic                          inwidth,
   input  logic                          wwidth,
   input  logic                          st,
   input  logic [NOUT_W-1:0]             nout,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [SEQ_W+3+NOUT_W-1:0]     out_data,
   output logic                          busy,
   output logic [$clog2(DEPTH+1)-1:0]    level,
   output logic                          ovf,
   output logic                          tmo,
   output logic                          spur,
   input  logic                          clr_err
);

   localparam int TAG_W = SEQ_W + TAG_MODE_W;
   localparam int CNT_W = $clog2(TIMEOUT) + 1;

   dcim_state_e      state_q, state_d;
   logic [TAG_W-1:0] tag_q, tag_d;
   logic [SEQ_W-1:0] seq_q, seq_d, seq_inc;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             st_q, st_rise;
   logic             ovf_q, tmo_q, spur_q;
   logic             push, set_ovf, set_tmo, set_spur;
   logic             fifo_full, fifo_pop;
   logic [TAG_MODE_W-1:0] mode;

   assign st_rise  = st & ~st_q;
   assign seq_inc  = seq_q + 1'b1;
   assign mode     = pack_mode(cima, inwidth, wwidth);
   assign fifo_pop = out_valid & out_ready;
   assign set_ovf  = push & fifo_full & ~fifo_pop;

   always_comb begin
      state_d  = state_q;
      tag_d    = tag_q;
      seq_d    = seq_q;
      cnt_d    = cnt_q;
      push     = 1'b0;
      set_tmo  = 1'b0;
      set_spur = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (st_rise) set_spur = 1'b1;
            if (start) begin
               tag_d   = {seq_q, mode};
               cnt_d   = '0;
               state_d = ST_ARMED;
            end
         end
         ST_ARMED: begin
            cnt_d = cnt_q + 1'b1;
            if (st_rise) begin
               push  = 1'b1;
               seq_d = seq_inc;
               if (start) begin
                  tag_d = {seq_inc, mode};
                  cnt_d = '0;
               end else begin
                  state_d = ST_IDLE;
               end
            end else if (start) begin
               // Re-arm: the abandoned job's sequence number is consumed, never reported.
               tag_d = {seq_inc, mode};
               seq_d = seq_inc;
               cnt_d = '0;
            end else if (cnt_q == CNT_W'(TIMEOUT-1)) begin
               set_tmo = 1'b1;
               seq_d   = seq_inc;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         seq_q   <= '0;
         cnt_q   <= '0;
         st_q    <= 1'b0;
         ovf_q   <= 1'b0;
         tmo_q   <= 1'b0;
         spur_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         seq_q   <= seq_d;
         cnt_q   <= cnt_d;
         st_q    <= st;
         // A new error event in the same cycle takes priority over clr_err.
         ovf_q   <= set_ovf  | (ovf_q  & ~clr_err);
         tmo_q   <= set_tmo  | (tmo_q  & ~clr_err);
         spur_q  <= set_spur | (spur_q & ~clr_err);
      end
   end

   always_ff @(posedge clk) begin
      tag_q <= tag_d;
   end

   dcim_sync_fifo #(
      .WIDTH (TAG_W + NOUT_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (push),
      .data_i  ({tag_q, nout}),
      .pop_i   (fifo_pop),
      .data_o  (out_data),
      .valid_o (out_valid),
      .full_o  (fifo_full),
      .level_o (level)
   );

   assign busy = (state_q == ST_ARMED);
   assign ovf  = ovf_q;
   assign tmo  = tmo_q;
   assign spur = spur_q;

endmodule

// File: tb/tb_dcim_result_collector.sv
// Scoreboarded bench for dcim_result_collector: a main instance (TIMEOUT=1024) and a
// short-timeout instance (TIMEOUT=16) share all inputs.
module tb_dcim_result_collector;

   localparam int NW = 51;
   localparam int SW = 4;
   localparam int DP = 4;
   localparam int DW = SW + 3 + NW;
   localparam int LW = $clog2(DP+1);

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          start = 1'b0, cima = 1'b0, inwidth = 1'b0, wwidth = 1'b0;
   logic          st = 1'b0, out_ready = 1'b0, clr_err = 1'b0;
   logic [NW-1:0] nout = '0;

   logic          out_valid, busy, ovf, tmo, spur;
   logic [DW-1:0] out_data;
   logic [LW-1:0] level;
   logic          t_out_valid, t_busy, t_ovf, t_tmo, t_spur;
   logic [DW-1:0] t_out_data;
   logic [LW-1:0] t_level;

   dcim_result_collector #(.NOUT_W(NW), .SEQ_W(SW), .DEPTH(DP), .TIMEOUT(1024)) dut (
      .clk(clk), .rst(rst), .start(start), .cima(cima), .inwidth(inwidth), .wwidth(wwidth),
      .st(st), .nout(nout), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .busy(busy), .level(level), .ovf(ovf), .tmo(tmo), .spur(spur), .clr_err(clr_err));

   dcim_result_collector #(.NOUT_W(NW), .SEQ_W(SW), .DEPTH(DP), .TIMEOUT(16)) dut_t (
      .clk(clk), .rst(rst), .start(start), .cima(cima), .inwidth(inwidth), .wwidth(wwidth),
      .st(st), .nout(nout), .out_valid(t_out_valid), .out_ready(out_ready),
      .out_data(t_out_data), .busy(t_busy), .level(t_level), .ovf(t_ovf), .tmo(t_tmo),
      .spur(t_spur), .clr_err(clr_err));

   always #5 clk = ~clk;

   int            n_checks = 0;
   int            n_fail = 0;
   logic [DW-1:0] sb_q[$];

   typedef struct {
      logic          c;
      logic          i;
      logic          w;
      logic [NW-1:0] v;
      int            dly;
      logic [DW-1:0] exp;
   } vec_t;
   vec_t tbl[4];

   function automatic logic [DW-1:0] mk(input int s, input logic c, input logic i,
                                        input logic w, input logic [NW-1:0] v);
      return {SW'(s), c, i, w, v};
   endfunction

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // One clock: scoreboard compare at the negedge, return 1 time unit after the posedge.
   task automatic cyc();
      logic [DW-1:0] e;
      @(negedge clk);
      if (!rst && out_valid && out_ready) begin
         if (sb_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL sb_unexpected: got %0h expected no output", out_data);
         end else begin
            e = sb_q.pop_front();
            check("sb_data", 64'(out_data), 64'(e));
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic launch(input logic c, input logic i, input logic w);
      start = 1'b1; cima = c; inwidth = i; wwidth = w;
      cyc();
      start = 1'b0;
   endtask

   task automatic finish(input logic [NW-1:0] v);
      st = 1'b1; nout = v;
      cyc();
      st = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1; start = 1'b0; st = 1'b0; clr_err = 1'b0; out_ready = 1'b0;
      sb_q.delete();
      cyc(); cyc();
      rst = 1'b0;
      cyc();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [DW-1:0] e1;
      tbl[0] = '{1'b0, 1'b0, 1'b0, 51'h0,              0,  mk(1, 1'b0, 1'b0, 1'b0, 51'h0)};
      tbl[1] = '{1'b1, 1'b1, 1'b1, 51'h7_FFFF_FFFF_FFFF, 3, mk(2, 1'b1, 1'b1, 1'b1, 51'h7_FFFF_FFFF_FFFF)};
      tbl[2] = '{1'b0, 1'b1, 1'b0, 51'h2_AAAA_5555_0F0F, 7, mk(3, 1'b0, 1'b1, 1'b0, 51'h2_AAAA_5555_0F0F)};
      tbl[3] = '{1'b1, 1'b0, 1'b0, 51'h1,              12, mk(4, 1'b1, 1'b0, 1'b0, 51'h1)};

      // Reset values
      #1 rst = 1'b1;
      #1;
      check("rst_valid", 64'(out_valid), 64'(0));
      check("rst_data",  64'(out_data),  64'(0));
      check("rst_busy",  64'(busy),      64'(0));
      check("rst_level", 64'(level),     64'(0));
      check("rst_flags", 64'({ovf, tmo, spur}), 64'(0));
      cyc(); cyc();
      rst = 1'b0;
      cyc();

      // Test 1: single job, st 20 cycles after start
      launch(1'b1, 1'b0, 1'b1);
      check("t1_busy_armed", 64'(busy), 64'(1));
      repeat (19) cyc();
      e1 = mk(0, 1'b1, 1'b0, 1'b1, 51'h1_2345_6789_ABCD);
      sb_q.push_back(e1);
      finish(51'h1_2345_6789_ABCD);
      check("t1_valid", 64'(out_valid), 64'(1));
      check("t1_data",  64'(out_data),  64'(e1));
      check("t1_busy_done", 64'(busy), 64'(0));
      cyc();
      check("t1_data_hold", 64'(out_data), 64'(e1));
      check("t1_level", 64'(level), 64'(1));
      out_ready = 1'b1;
      cyc();
      check("t1_drained", 64'(out_valid), 64'(0));

      // Table of jobs with varied modes, data and latency
      for (int k = 0; k < 4; k++) begin
         launch(tbl[k].c, tbl[k].i, tbl[k].w);
         repeat (tbl[k].dly) cyc();
         sb_q.push_back(tbl[k].exp);
         finish(tbl[k].v);
         check("tbl_valid", 64'(out_valid), 64'(1));
         check("tbl_busy", 64'(busy), 64'(0));
         cyc();
      end
      check("tbl_sb_empty", 64'(sb_q.size()), 64'(0));

      // Test 2: back-pressure and overflow
      do_reset();
      for (int k = 0; k < 5; k++) begin
         launch(1'(k), 1'(k >> 1), 1'b1);
         repeat (2) cyc();
         if (k < 4) sb_q.push_back(mk(k, 1'(k), 1'(k >> 1), 1'b1, 51'(k * 1000 + 7)));
         finish(51'(k * 1000 + 7));
         if (k == 3) begin
            check("t2_full_level", 64'(level), 64'(4));
            check("t2_no_ovf_yet", 64'(ovf), 64'(0));
         end
      end
      check("t2_level", 64'(level), 64'(4));
      check("t2_ovf", 64'(ovf), 64'(1));
      out_ready = 1'b1;
      repeat (4) cyc();
      check("t2_drained", 64'(level), 64'(0));
      check("t2_sb_empty", 64'(sb_q.size()), 64'(0));
      launch(1'b0, 1'b0, 1'b0);
      cyc();
      sb_q.push_back(mk(5, 1'b0, 1'b0, 1'b0, 51'h55));
      finish(51'h55);
      cyc();
      check("t2_seq5_popped", 64'(sb_q.size()), 64'(0));
      clr_err = 1'b1;
      cyc();
      clr_err = 1'b0;
      check("t2_ovf_clr", 64'(ovf), 64'(0));

      // Test 3: timeout on the TIMEOUT=16 instance
      do_reset();
      launch(1'b1, 1'b1, 1'b1);
      repeat (15) cyc();
      check("t3_busy_before", 64'(t_busy), 64'(1));
      check("t3_tmo_before", 64'(t_tmo), 64'(0));
      cyc();
      check("t3_tmo", 64'(t_tmo), 64'(1));
      check("t3_busy_after", 64'(t_busy), 64'(0));
      check("t3_level", 64'(t_level), 64'(0));
      check("t3_main_no_tmo", 64'(tmo), 64'(0));
      clr_err = 1'b1;
      cyc();
      clr_err = 1'b0;
      check("t3_tmo_clr", 64'(t_tmo), 64'(0));
      launch(1'b0, 1'b0, 1'b0);
      finish(51'h5);
      check("t3_next_valid", 64'(t_out_valid), 64'(1));
      check("t3_next_seq", 64'(t_out_data[DW-1 -: SW]), 64'(1));
      check("t3_no_ovf", 64'(t_ovf), 64'(0));

      // Test 4: spurious st, clear collision, st held high through start
      do_reset();
      st = 1'b1;
      cyc();
      st = 1'b0;
      check("t4_spur", 64'(spur), 64'(1));
      check("t4_t_spur", 64'(t_spur), 64'(1));
      check("t4_no_push", 64'(level), 64'(0));
      check("t4_idle", 64'(busy), 64'(0));
      cyc();
      st = 1'b1; clr_err = 1'b1;
      cyc();
      clr_err = 1'b0;
      check("t4_set_wins", 64'(spur), 64'(1));
      clr_err = 1'b1;
      cyc();
      clr_err = 1'b0;
      check("t4_spur_clr", 64'(spur), 64'(0));
      launch(1'b1, 1'b0, 1'b0);
      repeat (15) cyc();
      check("t4_held_busy", 64'(t_busy), 64'(1));
      check("t4_held_nocap", 64'(level), 64'(0));
      cyc();
      check("t4_held_tmo", 64'(t_tmo), 64'(1));
      check("t4_held_idle", 64'(t_busy), 64'(0));
      check("t4_held_level", 64'(t_level), 64'(0));
      st = 1'b0;

      // Test 5: start with st_rise in ARMED, then push+pop on a full FIFO
      do_reset();
      out_ready = 1'b1;
      launch(1'b0, 1'b1, 1'b1);
      repeat (3) cyc();
      sb_q.push_back(mk(0, 1'b0, 1'b1, 1'b1, 51'hABC));
      start = 1'b1; cima = 1'b1; inwidth = 1'b0; wwidth = 1'b0; st = 1'b1; nout = 51'hABC;
      cyc();
      start = 1'b0; st = 1'b0;
      check("t5_rearmed", 64'(busy), 64'(1));
      check("t5_old_pushed", 64'(level), 64'(1));
      repeat (2) cyc();
      sb_q.push_back(mk(1, 1'b1, 1'b0, 1'b0, 51'hDEF));
      finish(51'hDEF);
      check("t5_new_done", 64'(busy), 64'(0));
      cyc();
      check("t5_sb_empty", 64'(sb_q.size()), 64'(0));
      out_ready = 1'b0;
      for (int k = 0; k < 4; k++) begin
         launch(1'b0, 1'b0, 1'b1);
         cyc();
         sb_q.push_back(mk(2 + k, 1'b0, 1'b0, 1'b1, 51'(k + 100)));
         finish(51'(k + 100));
      end
      check("t5_full", 64'(level), 64'(4));
      launch(1'b1, 1'b1, 1'b1);
      cyc();
      sb_q.push_back(mk(6, 1'b1, 1'b1, 1'b1, 51'h3C));
      st = 1'b1; nout = 51'h3C; out_ready = 1'b1;
      cyc();
      st = 1'b0; out_ready = 1'b0;
      check("t5_pushpop_level", 64'(level), 64'(4));
      check("t5_pushpop_no_ovf", 64'(ovf), 64'(0));
      out_ready = 1'b1;
      repeat (4) cyc();
      check("t5_drained", 64'(level), 64'(0));
      check("t5_sb_done", 64'(sb_q.size()), 64'(0));

      // Test 6: reset while armed with two queued results
      do_reset();
      launch(1'b0, 1'b0, 1'b0);
      finish(51'h11);
      launch(1'b1, 1'b1, 1'b1);
      finish(51'h22);
      launch(1'b0, 1'b1, 1'b0);
      check("t6_pre_busy", 64'(busy), 64'(1));
      check("t6_pre_level", 64'(level), 64'(2));
      #2 rst = 1'b1;
      #1;
      check("t6_valid", 64'(out_valid), 64'(0));
      check("t6_level", 64'(level), 64'(0));
      check("t6_busy", 64'(busy), 64'(0));
      check("t6_data", 64'(out_data), 64'(0));
      sb_q.delete();
      cyc();
      rst = 1'b0;
      cyc();
      out_ready = 1'b1;
      launch(1'b1, 1'b0, 1'b1);
      sb_q.push_back(mk(0, 1'b1, 1'b0, 1'b1, 51'h33));
      finish(51'h33);
      check("t6_post_seq", 64'(out_data[DW-1 -: SW]), 64'(0));
      cyc();
      check("t6_sb_empty", 64'(sb_q.size()), 64'(0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
